// File: rtl/filter.sv
// ----------------------------------------------------------------------------
// filter -- one band of the 8-band audio equalizer.
//
// Fixed-coefficient NTAPS-tap FIR with a fully serial datapath. There is one
// multiply-accumulate per enabled clock, so one sample goes in and one result
// comes out every NTAPS enabled clocks.
//
// Parameters
//   NTAPS  filter length, which is also the number of enabled clocks per frame
//   COEFF  Q1.15 taps. h[k] = COEFF[k], and h[0] applies to the newest sample.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   clk_enable  global enable; when low, every register holds
//   filter_in   signed 16-bit sample, captured only on a frame-start edge
//   filter_out  signed 16-bit saturated result, updated once per frame
// ----------------------------------------------------------------------------
module filter #(
   parameter int                      NTAPS = 64,
   parameter logic [NTAPS-1:0][15:0]  COEFF = {NTAPS{16'sd512}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clk_enable,
   input  logic signed [15:0] filter_in,
   output logic signed [15:0] filter_out
);

   localparam int PW = $clog2(NTAPS);

   logic        [PW-1:0] phase_q, phase_d;
   logic signed [15:0]   x_q [NTAPS];
   logic signed [39:0]   acc_q, acc_d;
   logic signed [15:0]   out_q, out_d;

   logic                 frame_start;
   logic signed [15:0]   mul_x;
   logic signed [15:0]   mul_h;
   logic signed [31:0]   prod;
   logic signed [39:0]   acc_shr;

   assign frame_start = (phase_q == '0);

   // On a frame start the shift has not happened yet, so the newest sample
   // comes straight from the input. On every later phase the delay line
   // already holds the post-shift data, and x_q[phase] is the correct operand.
   assign mul_x = frame_start ? filter_in : x_q[phase_q];
   assign mul_h = signed'(COEFF[phase_q]);
   assign prod  = mul_x * mul_h;

   // Arithmetic shift floors toward minus infinity. Clamping happens only here.
   assign acc_shr = acc_q >>> 15;

   always_comb begin
      phase_d = (phase_q == PW'(NTAPS - 1)) ? '0 : phase_q + PW'(1);
      acc_d   = frame_start ? 40'(prod) : acc_q + 40'(prod);
      out_d   = out_q;
      if (frame_start) begin
         if (acc_shr > 40'sd32767)
            out_d = 16'sh7fff;
         else if (acc_shr < -40'sd32768)
            out_d = -16'sh8000;
         else
            out_d = acc_shr[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
      end else if (clk_enable) begin
         phase_q <= phase_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         if (frame_start) begin
            for (int k = NTAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
            x_q[0] <= filter_in;
         end
      end
   end

   assign filter_out = out_q;

endmodule

// File: tb/tb_filter.sv
// ----------------------------------------------------------------------------
// tb_filter -- directed test of the serial FIR band filter.
//
// Instance u_dut uses the default taps (all 1/64). Instance u_sat uses
// all-32767 taps so that the output clamping can be driven into both rails.
// ----------------------------------------------------------------------------
module tb_filter;

   logic               clk;
   logic               rst;
   logic               clk_enable;
   logic signed [15:0] filter_in;
   logic signed [15:0] filter_out;
   logic signed [15:0] sat_in;
   logic signed [15:0] sat_out;

   int n_vec;
   int n_err;

   filter u_dut (
      .clk        (clk),
      .rst        (rst),
      .clk_enable (clk_enable),
      .filter_in  (filter_in),
      .filter_out (filter_out)
   );

   filter #(.COEFF({64{16'h7fff}})) u_sat (
      .clk        (clk),
      .rst        (rst),
      .clk_enable (clk_enable),
      .filter_in  (sat_in),
      .filter_out (sat_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Holds reset for a few clocks with enable high and junk on the input.
   // The output must stay 0 throughout. Reset is released on a falling edge,
   // so the next rising edge is the first frame start.
   task automatic do_reset();
      rst        = 1'b0;
      clk_enable = 1'b1;
      sat_in     = '0;
      for (int i = 0; i < 4; i++) begin
         filter_in = 16'($urandom);
         @(negedge clk);
         chk("reset_out", filter_out, 0);
      end
      rst = 1'b1;
   endtask

   // Runs one frame of 64 enabled clocks.
   //   - Checks the published output right after the frame-start edge.
   //   - Drives junk on the input during the rest of the frame.
   //   - Optionally stalls for 10 clocks before phase stall_at.
   //   - Checks that the output held until the end of the frame.
   // The hold check also catches a phase counter that kept running during the
   // stall, because such a counter would reach its frame start too early.
   task automatic frame(input string tag, input int s, input int exp,
                        input int ss, input int sexp, input bit chk_sat,
                        input int stall_at);
      logic signed [15:0] held;
      filter_in = 16'(s);
      sat_in    = 16'(ss);
      @(posedge clk); #1;
      chk(tag, filter_out, exp);
      if (chk_sat) chk({tag, "_sat"}, sat_out, sexp);
      held      = filter_out;
      filter_in = 16'($urandom);
      for (int p = 1; p < 64; p++) begin
         if (p == stall_at) begin
            clk_enable = 1'b0;
            repeat (10) @(posedge clk);
            #1 chk({tag, "_stall_hold"}, filter_out, held);
            clk_enable = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk({tag, "_frame_hold"}, filter_out, held);
   endtask

   initial begin
      int e;
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b0;
      clk_enable = 1'b1;
      filter_in  = '0;
      sat_in     = '0;

      // Impulse: 32767 followed by zeros.
      //   - Frame 1 publishes the empty accumulation, so 0.
      //   - Frames 2..65 publish 32767*512 >> 15 = 511.
      //   - Frames 66 and later publish 0.
      do_reset();
      for (int j = 1; j <= 67; j++) begin
         e = (j >= 2 && j <= 65) ? 511 : 0;
         frame("impulse", (j == 1) ? 32767 : 0, e, 0, 0, 1'b0, -1);
      end

      // Step of 1000 with a 10-clock stall at phase 30 of frame 3.
      // Frame j publishes floor(1000*512*min(j-1,64)/32768): 0, 15, 31, 46, ...
      // and 1000 once the delay line is full.
      do_reset();
      for (int j = 1; j <= 67; j++) begin
         e = (1000 * 512 * ((j - 1 > 64) ? 64 : j - 1)) >>> 15;
         frame("step", 1000, e, 0, 0, 1'b0, (j == 3) ? 30 : -1);
      end
      chk("step_final", filter_out, 1000);

      // Constant -1. Every published output after the first is floor(-n/64),
      // which is -1.
      do_reset();
      for (int j = 1; j <= 67; j++)
         frame("neg", -1, (j == 1) ? 0 : -1, 0, 0, 1'b0, -1);

      // Saturation on u_sat. The input is 32767 for frames 1-3, then -32768.
      // Expected outputs after each frame start:
      //   frame 2:  32767*32767 >> 15 = 32766
      //   frame 3:  two samples would give 65532, which clamps to 32767
      //   frame 5:  clamps to 32767
      //   frame 10: sum of 6 negative and 3 positive samples clamps to -32768
      do_reset();
      for (int j = 1; j <= 10; j++) begin
         case (j)
            2:       e = 32766;
            3, 5:    e = 32767;
            10:      e = -32768;
            default: e = 0;
         endcase
         frame("sat", 0, 0, (j <= 3) ? 32767 : -32768, e,
               (j == 2 || j == 3 || j == 5 || j == 10), -1);
      end

      // Reset asserted mid-frame clears the output without a clock edge.
      // After release the frame restarts from phase 0.
      do_reset();
      frame("mr", 1000, 0, 0, 0, 1'b0, -1);
      frame("mr", 1000, 15, 0, 0, 1'b0, -1);
      repeat (20) @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("midreset_async", filter_out, 0);
      @(negedge clk);
      rst = 1'b1;
      frame("mr_after", 1000, 0, 0, 0, 1'b0, -1);
      frame("mr_after", 1000, 15, 0, 0, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
